// File: rtl/mcu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store width codes and the legality/alignment rule.
package mcu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // True when the width code exists for this direction and the byte
    // offset is naturally aligned for that width.
    function automatic logic access_ok(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:  ok = 1'b1;
            F3_H:  ok = ~off[0];
            F3_W:  ok = (off == 2'b00);
            F3_BU: ok = ~we;
            F3_HU: ok = ~we & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align_n.sv
// Load data extraction: picks the addressed byte/half out of the bus word
// and sign- or zero-extends it to the full register width.
module lsu_align_n
    import mcu_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    // Shift the addressed lane down to bit 0, then extend by width code.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        rdata_o = '0;
        shifted = mem_rdata_i >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata_o = mem_rdata_i;
            F3_BU:   rdata_o = {24'h0, shifted[7:0]};
            F3_HU:   rdata_o = {16'h0, shifted[15:0]};
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_n.sv
// Load/store unit: runs one data-memory access per request over a
// req/gnt/rvalid bus and returns extended load data or an error pulse.
module lsu_n
    import mcu_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [2:0]   funct3_i,
    input  logic [n-1:0] addr_i,
    input  logic [n-1:0] wdata_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [n-1:0] rdata_o,
    output logic         mem_req_o,
    output logic         mem_we_o,
    output logic [n-1:0] mem_addr_o,
    output logic [3:0]   mem_be_o,
    output logic [n-1:0] mem_wdata_o,
    input  logic         mem_gnt_i,
    input  logic         mem_rvalid_i,
    input  logic [n-1:0] mem_rdata_i
);

    lsu_state_e   state_q, state_d;
    logic         we_q;
    logic [2:0]   f3_q;
    logic [n-1:0] addr_q;
    logic [n-1:0] wdata_q;
    logic         err_q;
    logic [n-1:0] rdata_q;

    logic         req_ok;
    logic         capture;
    logic [n-1:0] load_data;
    logic [3:0]   be;
    logic [n-1:0] wdata_rep;
    logic         in_req;

    assign req_ok = access_ok(we_i, funct3_i, addr_i[1:0]);

    // Read data arrives either with the grant or later in WAIT; stores
    // never touch rdata.
    assign capture = ~we_q & mem_rvalid_i &
                     (((state_q == REQ) & mem_gnt_i) | (state_q == WAIT));

    lsu_align_n u_align (
        .mem_rdata_i (mem_rdata_i),
        .off_i       (addr_q[1:0]),
        .funct3_i    (f3_q),
        .rdata_o     (load_data)
    );

    // Next-state logic for the IDLE -> REQ -> WAIT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_i) state_d = req_ok ? REQ : DONE;
            REQ:  if (mem_gnt_i) state_d = mem_rvalid_i ? DONE : WAIT;
            WAIT: if (mem_rvalid_i) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the request latch and load result register.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register sees the pre-edge value of the others.
        if (!rst_ni) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_i) begin
                we_q    <= we_i;
                f3_q    <= funct3_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= ~req_ok;
            end
            if (capture) begin
                rdata_q <= load_data;
            end
        end
    end

    // Byte enables and lane-replicated store data from the latched request.
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
        if (we_q) begin
            case (f3_q)
                F3_B: begin
                    be        = 4'b0001 << addr_q[1:0];
                    wdata_rep = {4{wdata_q[7:0]}};
                end
                F3_H: begin
                    be        = 4'b0011 << addr_q[1:0];
                    wdata_rep = {2{wdata_q[15:0]}};
                end
                default: begin
                    be        = 4'b1111;
                    wdata_rep = wdata_q;
                end
            endcase
        end
    end

    // Bus signals are only driven while the request is outstanding, so
    // they read as zero in every other state, including after reset.
    assign in_req      = (state_q == REQ);
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req & we_q;
    assign mem_addr_o  = in_req ? {addr_q[n-1:2], 2'b00} : '0;
    assign mem_be_o    = in_req ? be : 4'b0000;
    assign mem_wdata_o = in_req ? wdata_rep : '0;

    assign busy_o  = (state_q != IDLE);
    assign done_o  = (state_q == DONE);
    assign err_o   = (state_q == DONE) & err_q;
    assign rdata_o = rdata_q;

endmodule
